// File: rtl/pipe_scoreboard_if.sv
// pipe_scoreboard_if: decode/commit/issue signal bundle between decode, commit and the scoreboard.
interface pipe_scoreboard_if #(parameter int NREG = 32);
    logic            dec_valid;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic [4:0]      dec_rd;
    logic            dec_we;
    logic            redirect;
    logic            cmt_we;
    logic [4:0]      cmt_rd;
    logic            stall;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic [NREG-1:0] busy;
    logic            err_uflow;
    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_we, redirect, cmt_we, cmt_rd,
        input  stall, issue_valid, issue_rd, busy, err_uflow
    );
    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_we, redirect, cmt_we, cmt_rd,
        output stall, issue_valid, issue_rd, busy, err_uflow
    );
endinterface

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: RAW/saturation issue gating, redirect flush, commit-driven release of destinations.
// SB_STATS_EN adds the stall_cnt/issue_cnt statistics outputs.
module pipe_scoreboard #(
    parameter int NREG      = 32,
    parameter int CNT_W     = 2,
    parameter int FLUSH_CYC = 2
) (
    input  logic                 clk,
    input  logic                 nrst,
    pipe_scoreboard_if.slave     sb
`ifdef SB_STATS_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          issue_cnt
`endif
);
    localparam logic [CNT_W-1:0] MAX = '1;
    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
    state_t           r_state, w_state_nxt;
    logic [2:0]       r_fcnt, w_fcnt_nxt;
    logic [CNT_W-1:0] r_pend [NREG];
    logic             r_issue_valid;
    logic [4:0]       r_issue_rd;
    logic             r_err;
    logic [NREG-1:0]  w_inc, w_dec, w_busy;
    logic             w_hazard, w_accept, w_uflow;

    // Hazards look only at registered pending counts: no same-cycle commit bypass.
    always_comb begin
        w_hazard = sb.dec_valid &
                   ((sb.dec_rs1 != '0 && r_pend[sb.dec_rs1] != '0) |
                    (sb.dec_rs2 != '0 && r_pend[sb.dec_rs2] != '0) |
                    (sb.dec_we && sb.dec_rd != '0 && r_pend[sb.dec_rd] == MAX));
        w_uflow  = sb.cmt_we && sb.cmt_rd != '0 && r_pend[sb.cmt_rd] == '0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        w_accept    = 1'b0;
        if (r_state == FLUSH) begin
            if (sb.redirect)
                w_fcnt_nxt = 3'(FLUSH_CYC - 1);
            else if (r_fcnt == '0)
                w_state_nxt = RUN;
            else
                w_fcnt_nxt = r_fcnt - 3'd1;
        end else if (sb.redirect) begin
            w_state_nxt = FLUSH;
            w_fcnt_nxt  = 3'(FLUSH_CYC - 1);
        end else if (w_hazard) begin
            w_state_nxt = STALL;
        end else begin
            w_state_nxt = RUN;
            w_accept    = sb.dec_valid;
        end
    end

    // x0 is never tracked, so index 0 stays out of every vector.
    always_comb begin
        w_inc  = '0;
        w_dec  = '0;
        w_busy = '0;
        for (int i = 1; i < NREG; i++) begin
            w_inc[i]  = w_accept && sb.dec_we && sb.dec_rd == 5'(i);
            w_dec[i]  = sb.cmt_we && sb.cmt_rd == 5'(i) && r_pend[i] != '0;
            w_busy[i] = r_pend[i] != '0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state       <= RUN;
            r_fcnt        <= '0;
            r_issue_valid <= 1'b0;
            r_issue_rd    <= '0;
            r_err         <= 1'b0;
            for (int i = 0; i < NREG; i++)
                r_pend[i] <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_fcnt        <= w_fcnt_nxt;
            r_issue_valid <= w_accept;
            r_issue_rd    <= (w_accept && sb.dec_we) ? sb.dec_rd : '0;
            r_err         <= r_err | w_uflow;
            for (int i = 0; i < NREG; i++)
                r_pend[i] <= r_pend[i] + CNT_W'(w_inc[i]) - CNT_W'(w_dec[i]);
        end
    end

    assign sb.stall       = (r_state == FLUSH) | w_hazard;
    assign sb.issue_valid = r_issue_valid;
    assign sb.issue_rd    = r_issue_rd;
    assign sb.busy        = w_busy;
    assign sb.err_uflow   = r_err;

`ifdef SB_STATS_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stall_cnt <= '0;
            issue_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + 32'(sb.stall & sb.dec_valid);
            issue_cnt <= issue_cnt + 32'(w_accept);
        end
    end
`endif
endmodule

// File: tb/tb_pipe_scoreboard.sv
// tb_pipe_scoreboard: directed checks of hazard gating, flush, saturation, underflow and x0 handling.
module tb_pipe_scoreboard;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    pipe_scoreboard_if sb ();
`ifdef SB_STATS_EN
    logic [31:0] stall_cnt, issue_cnt;
    pipe_scoreboard dut (.clk(clk), .nrst(nrst), .sb(sb), .stall_cnt(stall_cnt), .issue_cnt(issue_cnt));
`else
    pipe_scoreboard dut (.clk(clk), .nrst(nrst), .sb(sb));
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we);
        sb.dec_valid = v;
        sb.dec_rs1   = rs1;
        sb.dec_rs2   = rs2;
        sb.dec_rd    = rd;
        sb.dec_we    = we;
    endtask

    task automatic cmt(input logic we, input logic [4:0] rd);
        sb.cmt_we = we;
        sb.cmt_rd = rd;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        dec(0, 0, 0, 0, 0);
        cmt(0, 0);
        sb.redirect = 1'b0;
        #12;
        chk("rst_stall", 32'(sb.stall), 0);
        chk("rst_iv", 32'(sb.issue_valid), 0);
        chk("rst_ird", 32'(sb.issue_rd), 0);
        chk("rst_busy", sb.busy, 0);
        chk("rst_err", 32'(sb.err_uflow), 0);
        #5 nrst = 1'b1;
        tick();
        // no hazard: back-to-back writes to x1..x3
        dec(1, 0, 0, 1, 1);
        #1 chk("nh_stall", 32'(sb.stall), 0);
        tick();
        chk("nh_iv1", 32'(sb.issue_valid), 1);
        chk("nh_rd1", 32'(sb.issue_rd), 1);
        dec(1, 0, 0, 2, 1);
        tick();
        chk("nh_rd2", 32'(sb.issue_rd), 2);
        dec(1, 0, 0, 3, 1);
        tick();
        chk("nh_rd3", 32'(sb.issue_rd), 3);
        chk("nh_busy", sb.busy, 32'h0000_000E);
        dec(0, 0, 0, 0, 0);
        tick();
        chk("nh_iv0", 32'(sb.issue_valid), 0);
        cmt(1, 1);
        tick();
        cmt(1, 2);
        tick();
        cmt(1, 3);
        tick();
        cmt(0, 0);
        chk("nh_free", sb.busy, 0);
        // RAW on x5
        dec(1, 0, 0, 5, 1);
        tick();
        chk("raw_iv", 32'(sb.issue_valid), 1);
        chk("raw_busy5", 32'(sb.busy[5]), 1);
        dec(1, 5, 0, 6, 1);
        #1 chk("raw_stall", 32'(sb.stall), 1);
        tick();
        chk("raw_iv_held", 32'(sb.issue_valid), 0);
        cmt(1, 5);
        #1 chk("raw_nobypass", 32'(sb.stall), 1);
        tick();
        cmt(0, 0);
        chk("raw_busy5_clr", 32'(sb.busy[5]), 0);
        #1 chk("raw_release", 32'(sb.stall), 0);
        tick();
        chk("raw_iv2", 32'(sb.issue_valid), 1);
        chk("raw_rd6", 32'(sb.issue_rd), 6);
        dec(0, 0, 0, 0, 0);
        cmt(1, 6);
        tick();
        cmt(0, 0);
        // redirect flush
        dec(1, 0, 0, 10, 1);
        tick();
        dec(1, 0, 0, 11, 1);
        sb.redirect = 1'b1;
        #1 chk("rd_stall0", 32'(sb.stall), 0);
        tick();
        sb.redirect = 1'b0;
        chk("rd_iv_win", 32'(sb.issue_valid), 0);
        #1 chk("rd_flush1", 32'(sb.stall), 1);
        tick();
        chk("rd_iv_f1", 32'(sb.issue_valid), 0);
        chk("rd_flush2", 32'(sb.stall), 1);
        chk("rd_busy10", sb.busy, 32'h0000_0400);
        tick();
        chk("rd_iv_f2", 32'(sb.issue_valid), 0);
        chk("rd_run", 32'(sb.stall), 0);
        tick();
        chk("rd_iv_run", 32'(sb.issue_valid), 1);
        chk("rd_rd11", 32'(sb.issue_rd), 11);
        chk("rd_busy", sb.busy, 32'h0000_0C00);
        dec(0, 0, 0, 0, 0);
        cmt(1, 10);
        tick();
        cmt(1, 11);
        tick();
        cmt(0, 0);
        // saturation on x7
        dec(1, 0, 0, 7, 1);
        tick();
        tick();
        tick();
        chk("sat_pend3", 32'(dut.r_pend[7]), 3);
        chk("sat_stall", 32'(sb.stall), 1);
        cmt(1, 7);
        tick();
        cmt(0, 0);
        chk("sat_iv_held", 32'(sb.issue_valid), 0);
        #1 chk("sat_release", 32'(sb.stall), 0);
        tick();
        chk("sat_iv", 32'(sb.issue_valid), 1);
        chk("sat_rd7", 32'(sb.issue_rd), 7);
        chk("sat_pend_again", 32'(dut.r_pend[7]), 3);
        dec(0, 0, 0, 0, 0);
        cmt(1, 7);
        tick();
        tick();
        tick();
        cmt(0, 0);
        chk("sat_free", sb.busy, 0);
        // same-cycle issue + commit on x9, then underflow on x4
        dec(1, 0, 0, 9, 1);
        tick();
        cmt(1, 9);
        #1 chk("ic_stall", 32'(sb.stall), 0);
        tick();
        chk("ic_pend9", 32'(dut.r_pend[9]), 1);
        chk("ic_busy9", 32'(sb.busy[9]), 1);
        chk("ic_iv", 32'(sb.issue_valid), 1);
        dec(0, 0, 0, 0, 0);
        chk("uf_err0", 32'(sb.err_uflow), 0);
        cmt(1, 4);
        tick();
        chk("uf_err1", 32'(sb.err_uflow), 1);
        chk("uf_busy", sb.busy, 32'h0000_0200);
        cmt(0, 0);
        tick();
        chk("uf_sticky", 32'(sb.err_uflow), 1);
        // reset during a stall
        dec(1, 0, 0, 5, 1);
        tick();
        dec(1, 5, 0, 0, 0);
        #1 chk("mr_stall", 32'(sb.stall), 1);
        tick();
        #1 nrst = 1'b0;
        #1;
        chk("mr_stall0", 32'(sb.stall), 0);
        chk("mr_busy", sb.busy, 0);
        chk("mr_err", 32'(sb.err_uflow), 0);
        chk("mr_iv", 32'(sb.issue_valid), 0);
        dec(0, 0, 0, 0, 0);
        #1 nrst = 1'b1;
        tick();
        // x0 is never tracked
        dec(1, 0, 0, 0, 1);
        #1 chk("x0_stall_a", 32'(sb.stall), 0);
        tick();
        chk("x0_iv", 32'(sb.issue_valid), 1);
        chk("x0_rd", 32'(sb.issue_rd), 0);
        dec(1, 0, 0, 0, 0);
        #1 chk("x0_stall_b", 32'(sb.stall), 0);
        tick();
        chk("x0_iv2", 32'(sb.issue_valid), 1);
        chk("x0_busy", sb.busy, 0);
        dec(0, 0, 0, 0, 0);
`ifdef SB_STATS_EN
        chk("st_issue", issue_cnt, 2);
        chk("st_stall", stall_cnt, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
